// File: rtl/uart_rx.sv
// 8N1 serial receiver: oversamples a 2-flop-synchronized line, samples mid-bit, strobes each byte.
// Optional UART_RX_FRAME_ERR_EN adds o_RX_Frame_Err and drops bytes whose stop bit reads 0.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       o_RX_Frame_Err
`endif
);

  // state   | meaning
  // IDLE    | waiting for a falling edge on an armed (seen-high) line
  // START   | counting to mid start bit, rejecting glitches
  // DATA    | sampling 8 data bits LSB first, one bit period apart
  // STOP    | sampling the stop bit, publishing the byte
  // CLEANUP | one-cycle gap; DV drops, receiver must see high again to re-arm
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] BIT_CNT  = CW'(CLKS_PER_BIT - 1);

  state_t        state, state_nx;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          armed, armed_nx;
  logic          dv_nx;
  logic [7:0]    byte_nx;
  logic          stop_ok;
  logic          stop_sample;

`ifdef UART_RX_FRAME_ERR_EN
  logic          fe_nx;
  assign stop_ok = rx_sync;
`else
  assign stop_ok = 1'b1;
`endif

  assign stop_sample = (state == STOP) && (cnt == BIT_CNT);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      armed     <= 1'b0;
      o_RX_DV   <= 1'b0;
      o_RX_Byte <= 8'h00;
`ifdef UART_RX_FRAME_ERR_EN
      o_RX_Frame_Err <= 1'b0;
`endif
    end else begin
      rx_meta   <= i_RX_Serial;
      rx_sync   <= rx_meta;
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      shift     <= shift_nx;
      armed     <= armed_nx;
      o_RX_DV   <= dv_nx;
      o_RX_Byte <= byte_nx;
`ifdef UART_RX_FRAME_ERR_EN
      o_RX_Frame_Err <= fe_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shift_nx = shift;
    armed_nx = armed;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        idx_nx = '0;
        if (rx_sync) armed_nx = 1'b1;
        else if (armed) state_nx = START;
      end
      START: begin
        if (cnt == HALF_CNT) begin
          cnt_nx   = '0;
          state_nx = rx_sync ? IDLE : DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_CNT) begin
          cnt_nx        = '0;
          shift_nx[idx] = rx_sync;
          if (idx == 3'd7) state_nx = STOP;
          else idx_nx = idx + 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_CNT) begin
          cnt_nx   = '0;
          armed_nx = 1'b0;
          state_nx = CLEANUP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      CLEANUP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dv_nx   = 1'b0;
    byte_nx = o_RX_Byte;
`ifdef UART_RX_FRAME_ERR_EN
    fe_nx   = 1'b0;
`endif
    if (stop_sample) begin
      if (stop_ok) begin
        dv_nx   = 1'b1;
        byte_nx = shift;
      end
`ifdef UART_RX_FRAME_ERR_EN
      else begin
        fe_nx = 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven on clock-aligned times, DV/frame-error strobes logged on negedge.
module tb_uart_rx;
  localparam int CPB    = 217;
  localparam int CLK_NS = 40;
  localparam int BIT_NS = CPB * CLK_NS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       dv;
  logic [7:0] rbyte;
`ifdef UART_RX_FRAME_ERR_EN
  logic       fe;
`endif

  always #(CLK_NS / 2) clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_RX_Serial(rx),
    .o_RX_DV    (dv),
    .o_RX_Byte  (rbyte)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .o_RX_Frame_Err(fe)
`endif
  );

  int         dv_cnt = 0;
  int         fe_cnt = 0;
  logic [7:0] dv_q[$];

  always @(negedge clk) begin
    if (dv === 1'b1) begin
      dv_cnt++;
      dv_q.push_back(rbyte);
    end
`ifdef UART_RX_FRAME_ERR_EN
    if (fe === 1'b1) fe_cnt++;
`endif
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    return (dv_q.size() > i) ? {24'h0, dv_q[i]} : 32'hDEAD;
  endfunction

  task automatic send(input logic [7:0] b, input logic stop_bit, input int bit_ns, input int stretch_ns);
    rx = 1'b0;
    #(bit_ns + stretch_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
    rx = 1'b1;
  endtask

  initial begin
    int         dv_base;
    int         fe_base;
    logic [7:0] part;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_dv", {31'h0, dv}, 32'h0);
    check("rst_byte", {24'h0, rbyte}, 32'h00);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_no_dv", dv_cnt, 0);

    // stretched start bit, slightly fast transmitter
    dv_base = dv_cnt;
    dv_q.delete();
    send(8'h37, 1'b1, 8600, 1000);
    check("t1_dv_count", dv_cnt - dv_base, 1);
    check("t1_byte", {24'h0, rbyte}, 32'h37);

    // back-to-back frames
    repeat (2 * CPB) @(negedge clk);
    dv_base = dv_cnt;
    dv_q.delete();
    send(8'h00, 1'b1, BIT_NS, 0);
    send(8'hFF, 1'b1, BIT_NS, 0);
    send(8'hA5, 1'b1, BIT_NS, 0);
    check("t2_dv_count", dv_cnt - dv_base, 3);
    check("t2_q0", q_at(0), 32'h00);
    check("t2_q1", q_at(1), 32'hFF);
    check("t2_q2", q_at(2), 32'hA5);

    // short glitch rejected
    repeat (2 * CPB) @(negedge clk);
    dv_base = dv_cnt;
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("t3_glitch_no_dv", dv_cnt - dv_base, 0);
    check("t3_glitch_byte", {24'h0, rbyte}, 32'hA5);
    dv_q.delete();
    send(8'h5A, 1'b1, BIT_NS, 0);
    check("t3_dv_count", dv_cnt - dv_base, 1);
    check("t3_byte", {24'h0, rbyte}, 32'h5A);

    // stop bit low
    repeat (2 * CPB) @(negedge clk);
    dv_base = dv_cnt;
    fe_base = fe_cnt;
    send(8'hC3, 1'b0, BIT_NS, 0);
    repeat (2 * CPB) @(negedge clk);
`ifdef UART_RX_FRAME_ERR_EN
    check("t4_fe_count", fe_cnt - fe_base, 1);
    check("t4_dv_count", dv_cnt - dv_base, 0);
    check("t4_byte", {24'h0, rbyte}, 32'h5A);
`else
    check("t4_dv_count", dv_cnt - dv_base, 1);
    check("t4_byte", {24'h0, rbyte}, 32'hC3);
`endif

    // reset in the middle of data bit 4; bits 4..7 and stop are high
    repeat (2 * CPB) @(negedge clk);
    dv_base = dv_cnt;
    part = 8'hF5;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = part[i];
      #(BIT_NS);
    end
    rx = part[4];
    #(108 * CLK_NS);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_rst_byte", {24'h0, rbyte}, 32'h00);
    rst = 1'b0;
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("t5_after_dv", dv_cnt - dv_base, 0);
    check("t5_after_byte", {24'h0, rbyte}, 32'h00);
    send(8'h81, 1'b1, BIT_NS, 0);
    check("t5_dv_count", dv_cnt - dv_base, 1);
    check("t5_byte", {24'h0, rbyte}, 32'h81);

    // break: one event at most, then normal reception
    repeat (2 * CPB) @(negedge clk);
    dv_base = dv_cnt;
    fe_base = fe_cnt;
    rx = 1'b0;
    #(20 * BIT_NS);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("t6_break_events", (dv_cnt - dv_base) + (fe_cnt - fe_base), 1);
`ifdef UART_RX_FRAME_ERR_EN
    check("t6_break_byte", {24'h0, rbyte}, 32'h81);
`else
    check("t6_break_byte", {24'h0, rbyte}, 32'h00);
`endif
    dv_base = dv_cnt;
    send(8'h3C, 1'b1, BIT_NS, 0);
    check("t6_dv_count", dv_cnt - dv_base, 1);
    check("t6_byte", {24'h0, rbyte}, 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
